// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: forward selects, FSM states, zero register.
package pipe_pkg;
   localparam logic [1:0] FWD_RF     = 2'b00;
   localparam logic [1:0] FWD_EXALU  = 2'b01;
   localparam logic [1:0] FWD_MEMALU = 2'b10;
   localparam logic [1:0] FWD_MEMLD  = 2'b11;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic {
      IDLE   = 1'b0,
      MD_RUN = 1'b1
   } state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding select for one ID-stage operand; EX ALU result beats anything in MEM.
module fwd_sel
   import pipe_pkg::*;
(
   input  logic [4:0] src,
   input  logic       use_src,
   input  logic [4:0] ex_rd,
   input  logic       ex_wreg,
   input  logic       ex_m2reg,
   input  logic [4:0] mem_rd,
   input  logic       mem_wreg,
   input  logic       mem_m2reg,
   output logic [1:0] sel
);
   always_comb begin
      sel = FWD_RF;
      if (use_src && (src != REG_ZERO)) begin
         // A load still in EX has no data yet; that case is a stall, not a forward.
         if (ex_wreg && !ex_m2reg && (ex_rd == src))
            sel = FWD_EXALU;
         else if (mem_wreg && (mem_rd == src))
            sel = mem_m2reg ? FWD_MEMLD : FWD_MEMALU;
      end
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: load-use and mul/div stalls, ID forwarding, branch squash, perf counters.
// All controls are combinational on the current cycle's pipeline state.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MD_CYCLES  = 8,
   parameter int DELAY_SLOT = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_md,
   input  logic [4:0]       ex_rd,
   input  logic             ex_wreg,
   input  logic             ex_m2reg,
   input  logic [4:0]       mem_rd,
   input  logic             mem_wreg,
   input  logic             mem_m2reg,
   input  logic             md_start,
   input  logic             br_taken,
   output logic             stall,
   output logic             bubble,
   output logic             flush_if,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam int MDW = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;

   state_t           state_q, state_d;
   logic [MDW-1:0]   md_cnt_q, md_cnt_d;
   logic             load_use;
   logic             md_hz;

   fwd_sel u_fwd_a (
      .src(id_rs), .use_src(id_use_rs),
      .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
      .mem_rd(mem_rd), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
      .sel(fwd_a)
   );

   fwd_sel u_fwd_b (
      .src(id_rt), .use_src(id_use_rt),
      .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
      .mem_rd(mem_rd), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
      .sel(fwd_b)
   );

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q  <= IDLE;
         md_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
      end
   end

   // md_start during MD_RUN is ignored: the issue logic never lets it happen.
   always_comb begin
      state_d  = state_q;
      md_cnt_d = md_cnt_q;
      case (state_q)
         IDLE: begin
            if (md_start) begin
               state_d  = MD_RUN;
               md_cnt_d = MDW'(MD_CYCLES - 1);
            end
         end
         MD_RUN: begin
            if (md_cnt_q == '0)
               state_d = IDLE;
            else
               md_cnt_d = md_cnt_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign load_use = ex_wreg && ex_m2reg && (ex_rd != REG_ZERO) &&
                     ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

   assign md_busy  = (state_q == MD_RUN);
   // The waiting mul/div issues in the last busy cycle, when the counter is 0.
   assign md_hz    = md_busy && id_md && (md_cnt_q != '0);
   assign stall    = load_use || md_hz;
   assign bubble   = stall;
   assign flush_if = (DELAY_SLOT == 0) && br_taken && !stall;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
         if (flush_if && (flush_cnt != {CNT_W{1'b1}}))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
   localparam int MDC  = 8;
   localparam int CW   = 16;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          clrn;
   logic [4:0]    id_rs, id_rt, ex_rd, mem_rd;
   logic          id_use_rs, id_use_rt, id_md, ex_wreg, ex_m2reg;
   logic          mem_wreg, mem_m2reg, md_start, br_taken;
   logic          stall, bubble, flush_if, md_busy;
   logic [1:0]    fwd_a, fwd_b;
   logic [CW-1:0] stall_cnt, flush_cnt;

   pipe_hazard_ctrl #(.MD_CYCLES(MDC), .DELAY_SLOT(0), .CNT_W(CW)) dut (
      .clk(clk), .clrn(clrn),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_md(id_md),
      .ex_rd(ex_rd), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
      .mem_rd(mem_rd), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
      .md_start(md_start), .br_taken(br_taken),
      .stall(stall), .bubble(bubble), .flush_if(flush_if),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .md_busy(md_busy),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] rs, rt;
      logic       urs, urt, md;
      logic [4:0] exrd;
      logic       exw, exl;
      logic [4:0] mrd;
      logic       mw, ml, mds, br;
   } in_t;

   typedef struct {
      logic       stall, bubble, flush;
      logic [1:0] fa, fb;
      logic       busy;
      int         sc, fc;
   } exp_t;

   exp_t expq[$];
   int   total = 0;
   int   bad   = 0;

   // Reference state: cycle index, first cycle at which the MD unit is free again, event counts.
   int cyc = 0;
   int busy_until = 0;
   int scnt = 0;
   int fcnt = 0;

   function automatic in_t zin();
      in_t i;
      i.rs = 0; i.rt = 0; i.urs = 0; i.urt = 0; i.md = 0;
      i.exrd = 0; i.exw = 0; i.exl = 0;
      i.mrd = 0; i.mw = 0; i.ml = 0; i.mds = 0; i.br = 0;
      return i;
   endfunction

   function automatic logic [1:0] fref(input logic [4:0] src, input logic u, input in_t i);
      if (!u || src == 0) return 2'd0;
      if (i.exw && !i.exl && i.exrd == src) return 2'd1;
      if (i.mw && i.mrd == src) return i.ml ? 2'd3 : 2'd2;
      return 2'd0;
   endfunction

   function automatic exp_t model(input in_t i);
      exp_t e;
      logic busy, lu, hz;
      int   rem;
      busy = (cyc < busy_until);
      rem  = busy_until - 1 - cyc;
      lu   = i.exw && i.exl && (i.exrd != 0) &&
             ((i.urs && i.rs == i.exrd) || (i.urt && i.rt == i.exrd));
      hz   = busy && i.md && (rem != 0);
      e.stall  = lu || hz;
      e.bubble = e.stall;
      e.flush  = i.br && !e.stall;
      e.fa     = fref(i.rs, i.urs, i);
      e.fb     = fref(i.rt, i.urt, i);
      e.busy   = busy;
      e.sc     = scnt;
      e.fc     = fcnt;
      return e;
   endfunction

   task automatic advance(input in_t i, input exp_t e);
      if (e.stall && scnt < MAXC) scnt++;
      if (e.flush && fcnt < MAXC) fcnt++;
      if (i.mds && !e.busy) busy_until = cyc + 1 + MDC;
      cyc++;
   endtask

   task automatic drive(input in_t i);
      id_rs = i.rs; id_rt = i.rt; id_use_rs = i.urs; id_use_rt = i.urt; id_md = i.md;
      ex_rd = i.exrd; ex_wreg = i.exw; ex_m2reg = i.exl;
      mem_rd = i.mrd; mem_wreg = i.mw; mem_m2reg = i.ml;
      md_start = i.mds; br_taken = i.br;
   endtask

   task automatic step(input in_t i);
      exp_t e;
      @(posedge clk);
      #1;
      drive(i);
      e = model(i);
      expq.push_back(e);
      advance(i, e);
   endtask

   task automatic rst_step(input in_t i);
      exp_t e;
      @(posedge clk);
      #1;
      drive(i);
      #1 clrn = 1'b0;
      scnt = 0; fcnt = 0; busy_until = 0;
      e = model(i);
      expq.push_back(e);
      advance(i, e);
      @(negedge clk);
      #1 clrn = 1'b1;
   endtask

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", n, act, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (expq.size() > 0) begin
         exp_t e;
         e = expq.pop_front();
         chk("stall",     32'(stall),     32'(e.stall));
         chk("bubble",    32'(bubble),    32'(e.bubble));
         chk("flush_if",  32'(flush_if),  32'(e.flush));
         chk("fwd_a",     32'(fwd_a),     32'(e.fa));
         chk("fwd_b",     32'(fwd_b),     32'(e.fb));
         chk("md_busy",   32'(md_busy),   32'(e.busy));
         chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
         chk("flush_cnt", 32'(flush_cnt), 32'(e.fc));
      end
   end

   initial begin
      in_t i;
      exp_t e;
      clrn = 1'b0;
      drive(zin());
      #2;
      e = model(zin());
      expq.push_back(e);
      @(negedge clk);
      #2 clrn = 1'b1;

      // lw $1 in EX, consumer reads $1 -> one stall; then load is in MEM -> forward load data.
      i = zin(); i.rs = 1; i.urs = 1; i.exrd = 1; i.exw = 1; i.exl = 1;
      step(i);
      i = zin(); i.rs = 1; i.urs = 1; i.exrd = 7; i.exw = 1; i.mrd = 1; i.mw = 1; i.ml = 1;
      step(i);
      // EX and MEM both write $2: EX wins, on both operands.
      i = zin(); i.rs = 2; i.urs = 1; i.rt = 2; i.urt = 1;
      i.exrd = 2; i.exw = 1; i.mrd = 2; i.mw = 1;
      step(i);
      // Register 0 never hazards or forwards.
      i = zin(); i.urs = 1; i.urt = 1; i.exw = 1; i.exl = 1; i.mw = 1;
      step(i);
      // MEM ALU forward on rt only.
      i = zin(); i.rt = 3; i.urt = 1; i.mrd = 3; i.mw = 1;
      step(i);
      // Taken branch alone squashes; with a load-use stall it does not.
      i = zin(); i.br = 1;
      step(i);
      i = zin(); i.br = 1; i.rt = 4; i.urt = 1; i.exrd = 4; i.exw = 1; i.exl = 1;
      step(i);

      // Mul/div: start, then a waiting mul/div in ID for the whole busy window and beyond.
      i = zin(); i.mds = 1;
      step(i);
      for (int k = 0; k < MDC + 2; k++) begin
         i = zin(); i.md = 1;
         step(i);
      end
      // Reset in the middle of MD_RUN.
      i = zin(); i.mds = 1;
      step(i);
      for (int k = 0; k < 3; k++) begin
         i = zin(); i.md = 1;
         step(i);
      end
      i = zin(); i.md = 1;
      rst_step(i);
      for (int k = 0; k < 2; k++) begin
         i = zin(); i.md = 1;
         step(i);
      end

      // Randomized traffic over a small register window to provoke collisions.
      for (int k = 0; k < 1500; k++) begin
         i.rs   = 5'($urandom_range(0, 3));
         i.rt   = 5'($urandom_range(0, 3));
         i.urs  = 1'($urandom_range(0, 1));
         i.urt  = 1'($urandom_range(0, 1));
         i.md   = 1'($urandom_range(0, 1));
         i.exrd = 5'($urandom_range(0, 3));
         i.exw  = 1'($urandom_range(0, 1));
         i.exl  = 1'($urandom_range(0, 1));
         i.mrd  = 5'($urandom_range(0, 3));
         i.mw   = 1'($urandom_range(0, 1));
         i.ml   = 1'($urandom_range(0, 1));
         i.br   = ($urandom_range(0, 3) == 0);
         i.mds  = (cyc >= busy_until) && ($urandom_range(0, 15) == 0);
         step(i);
      end

      // Hold a load-use hazard long enough to saturate the stall counter.
      i = zin(); i.rs = 5; i.urs = 1; i.exrd = 5; i.exw = 1; i.exl = 1; i.br = 1;
      for (int k = 0; k < MAXC + 4; k++) step(i);

      @(negedge clk);
      @(negedge clk);
      chk("drain", 32'(expq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
